// File: rtl/char_ram_pkg.sv
// ============================================================================
// char_ram_pkg : shared constants and types for the character RAM write path
// Revision     : 1.0
// ============================================================================
`default_nettype none

package char_ram_pkg;

  localparam int CHAR_ADDR_W = 13;
  localparam int CHAR_DATA_W = 7;
  localparam int CHAR_COLS   = 80;
  localparam int CHAR_ROWS   = 60;
  localparam int CHAR_COUNT  = CHAR_COLS * CHAR_ROWS;
  localparam logic [CHAR_DATA_W-1:0] BLANK_CHAR = 7'h20;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/char_ram_write_arbiter_picker.sv
// ============================================================================
// rr_priority_picker : combinational round-robin pick of the first valid
//                      requester at or after ptr (modulo NREQ)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module rr_priority_picker #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] valid,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      idx,
  output logic            any
);

  logic [7:0] valid_ext;

  assign valid_ext = 8'(valid);

  // Scan from the farthest offset back to ptr so the closest valid wins.
  always_comb begin
    logic [3:0] sum;
    sum = '0;
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
      if (valid_ext[sum[2:0]]) begin
        any = 1'b1;
        idx = sum[2:0];
      end
    end
  end

  assign grant = any ? (NREQ'(1) << idx) : '0;

endmodule

`default_nettype wire

// File: rtl/char_ram_write_arbiter.sv
// ============================================================================
// char_ram_write_arbiter : round-robin arbiter for character RAM port A with
//                          a built-in clear sweep. Build option:
//                          CLEAR_ON_RESET_EN (blank the screen after reset).
// Revision               : 1.0
// ============================================================================
`default_nettype none

module char_ram_write_arbiter
  import char_ram_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int ADDR_W     = char_ram_pkg::CHAR_ADDR_W,
  parameter int DATA_W     = char_ram_pkg::CHAR_DATA_W,
  parameter int CHAR_COUNT = char_ram_pkg::CHAR_COUNT,
  parameter logic [DATA_W-1:0] BLANK_CHAR = DATA_W'(char_ram_pkg::BLANK_CHAR)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   clear_start,
  output logic                   clear_busy,
  output logic                   ram_wr_en,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_data,
  output logic [2:0]             grant_id,
  output logic                   drop_pulse
);

`ifdef CLEAR_ON_RESET_EN
  localparam arb_state_t RESET_STATE = CLEAR;
  localparam logic       RESET_BUSY  = 1'b1;
`else
  localparam arb_state_t RESET_STATE = IDLE;
  localparam logic       RESET_BUSY  = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CHAR_COUNT - 1);

  arb_state_t        state;
  logic [2:0]        rr_ptr;
  logic [ADDR_W-1:0] cell_cnt;

  logic [NREQ-1:0]   pick_grant;
  logic [2:0]        pick_idx;
  logic              pick_any;
  logic              transfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_in_range;
  logic [2:0]        next_ptr;
  logic [ADDR_W-1:0] sweep_addr;

  rr_priority_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A clear request pre-empts arbitration in the same cycle.
  assign transfer  = (state == IDLE) && !clear_start && pick_any;
  assign req_ready = transfer ? pick_grant : '0;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_in_range = (sel_addr < ADDR_W'(CHAR_COUNT));
  assign next_ptr     = (pick_idx == 3'(NREQ - 1)) ? 3'd0 : pick_idx + 3'd1;
  assign sweep_addr   = clear_start ? '0 : cell_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_STATE;
      rr_ptr     <= '0;
      cell_cnt   <= '0;
      ram_wr_en  <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      grant_id   <= '0;
      drop_pulse <= 1'b0;
      clear_busy <= RESET_BUSY;
    end else begin
      ram_wr_en  <= 1'b0;
      drop_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            cell_cnt   <= '0;
            clear_busy <= 1'b1;
          end else if (transfer) begin
            rr_ptr   <= next_ptr;
            grant_id <= pick_idx;
            if (sel_in_range) begin
              ram_wr_en <= 1'b1;
              ram_addr  <= sel_addr;
              ram_data  <= sel_data;
            end else begin
              drop_pulse <= 1'b1;
            end
          end
        end
        CLEAR: begin
          ram_wr_en <= 1'b1;
          ram_addr  <= sweep_addr;
          ram_data  <= BLANK_CHAR;
          cell_cnt  <= sweep_addr + 1'b1;
          if (sweep_addr == LAST_CELL) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_char_ram_write_arbiter.sv
// ============================================================================
// tb_char_ram_write_arbiter : directed self-checking bench with a scoreboard of
//                             expected RAM-bus cycles
// Revision                  : 1.0
// ============================================================================
`default_nettype none

module tb_char_ram_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 13;
  localparam int DW   = 7;
  localparam int CNT  = 4800;
`ifdef CLEAR_ON_RESET_EN
  localparam bit RST_CLEAR = 1'b1;
`else
  localparam bit RST_CLEAR = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              clear_start;
  logic              clear_busy;
  logic              ram_wr_en;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_data;
  logic [2:0]        grant_id;
  logic              drop_pulse;

  char_ram_write_arbiter #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .ram_wr_en   (ram_wr_en),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .grant_id    (grant_id),
    .drop_pulse  (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          drop;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    id;
    bit            chk_ad;
    bit            chk_id;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Behavioural reference state
  int            m_ptr;
  bit            m_clear;
  int            m_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_known;
  logic [2:0]    m_id;
  bit            m_id_known;

  int obs_wr, obs_busy;
  int obs_addr[$];
  int obs_id[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_clear = RST_CLEAR; m_cnt = 0;
    m_addr = '0; m_data = '0; m_known = 1'b1;
    m_id = '0; m_id_known = 1'b1;
    q.delete();
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = DW'(d);
  endtask

  // Called just after a falling edge with this cycle's inputs applied.
  task automatic tick();
    exp_t          e;
    logic [NREQ-1:0] exp_ready;
    int            sel, c, j;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #1;
    exp_ready = '0;
    sel = -1;
    if (!m_clear && !clear_start)
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (sel < 0 && req_valid[j]) sel = j;
      end
    if (sel >= 0) exp_ready[sel] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("clear_busy", 32'(clear_busy), 32'(m_clear));
    if (clear_busy) obs_busy++;

    e.wr = 1'b0; e.drop = 1'b0; e.addr = m_addr; e.data = m_data;
    e.id = m_id; e.chk_ad = m_known; e.chk_id = m_id_known;
    if (m_clear) begin
      c = clear_start ? 0 : m_cnt;
      e.wr = 1'b1; e.addr = AW'(c); e.data = 7'h20; e.chk_ad = 1'b1; e.chk_id = 1'b0;
      m_addr = AW'(c); m_data = 7'h20; m_known = 1'b1; m_id_known = 1'b0;
      m_cnt = c + 1;
      if (c == CNT - 1) m_clear = 1'b0;
    end else if (clear_start) begin
      m_clear = 1'b1;
      m_cnt = 0;
    end else if (sel >= 0) begin
      a = req_addr[sel*AW +: AW];
      d = req_data[sel*DW +: DW];
      m_ptr = (sel + 1) % NREQ;
      e.id = 3'(sel); e.chk_id = 1'b1; m_id = 3'(sel); m_id_known = 1'b1;
      if (int'(a) >= CNT) begin
        e.drop = 1'b1; e.chk_ad = 1'b0; m_known = 1'b0;
      end else begin
        e.wr = 1'b1; e.addr = a; e.data = d; e.chk_ad = 1'b1;
        m_addr = a; m_data = d; m_known = 1'b1;
      end
    end
    q.push_back(e);

    @(negedge clk);
    chk("scoreboard_depth", 32'(q.size()), 32'd1);
    e = q.pop_front();
    chk("ram_wr_en", 32'(ram_wr_en), 32'(e.wr));
    chk("drop_pulse", 32'(drop_pulse), 32'(e.drop));
    if (e.chk_ad) begin
      chk("ram_addr", 32'(ram_addr), 32'(e.addr));
      chk("ram_data", 32'(ram_data), 32'(e.data));
    end
    if (e.chk_id) chk("grant_id", 32'(grant_id), 32'(e.id));
    if (ram_wr_en) begin
      obs_wr++;
      obs_addr.push_back(int'(ram_addr));
    end
    if (ram_wr_en || drop_pulse) obs_id.push_back(int'(grant_id));
  endtask

  task automatic run_sweep_out();
    int guard;
    guard = 0;
    while (m_clear && guard < 6000) begin
      tick();
      guard++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(ram_wr_en), 32'd0);
    chk({tag, "_addr"},  32'(ram_addr),  32'd0);
    chk({tag, "_data"},  32'(ram_data),  32'd0);
    chk({tag, "_id"},    32'(grant_id),  32'd0);
    chk({tag, "_drop"},  32'(drop_pulse), 32'd0);
    chk({tag, "_busy"},  32'(clear_busy), 32'(RST_CLEAR));
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    int exp_seq[6];
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; clear_start = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: idle after reset, nothing requested
    repeat (20) tick();
    run_sweep_out();

    // 2: three requesters valid continuously
    set_req(0, 1, 10, 'h41); set_req(1, 1, 20, 'h42); set_req(2, 1, 30, 'h43);
    obs_addr.delete(); obs_id.delete();
    repeat (6) tick();
    exp_seq = '{10, 20, 30, 10, 20, 30};
    chk("rr_write_count", 32'(obs_addr.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk("rr_addr_seq", 32'(obs_addr[i]), 32'(exp_seq[i]));
      chk("rr_id_seq", 32'(obs_id[i]), 32'(i % 3));
    end
    req_valid = '0;
    tick();

    // 3: clear pre-empts a pending request, then the request is served
    set_req(1, 1, 77, 'h55);
    clear_start = 1'b1;
    obs_busy = 0; obs_wr = 0;
    tick();
    clear_start = 1'b0;
    repeat (CNT) tick();
    chk("sweep_busy_cycles", 32'(obs_busy), 32'(CNT));
    chk("sweep_writes", 32'(obs_wr), 32'(CNT));
    obs_id.delete();
    tick();
    chk("post_sweep_grant", 32'(obs_id.size() > 0 ? obs_id[0] : -1), 32'd1);
    req_valid = '0;
    tick();

    // 4: restart a sweep at cell 100
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (100) tick();
    clear_start = 1'b1;
    obs_wr = 0; obs_addr.delete();
    tick();
    clear_start = 1'b0;
    run_sweep_out();
    chk("restart_first_addr", 32'(obs_addr.size() > 0 ? obs_addr[0] : -1), 32'd0);
    chk("restart_writes", 32'(obs_wr), 32'(CNT));

    // 5: out-of-range address is accepted and dropped
    set_req(2, 1, 5000, 'h33);
    tick();
    chk("oor_drop_seen", 32'(drop_pulse), 32'd1);
    req_valid = '0;
    tick();
    set_req(0, 1, 1, 'h11); set_req(1, 1, 2, 'h12); set_req(2, 1, 3, 'h13);
    tick();
    chk("ptr_after_drop", 32'(grant_id), 32'd0);
    req_valid = '0;
    tick();

    // 6: asynchronous reset in the middle of a sweep
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (5) tick();
    run_sweep_out();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/char_ram_write_arbiter.md
Name: char_ram_write_arbiter

Overview:
Shares the single write port (port A) of the dual-port character RAM between NREQ text-writing requesters, such as the timer display, a status line and a score display. It uses round-robin arbitration and a one-write-per-cycle valid/ready handshake. It also contains a clear sequencer that sweeps every on-screen cell to a blank character. It sits between the writers and the characterRAM port A; port B (text generator read side) is untouched.

Parameters:
NREQ, 3, number of requesters (2..8)
ADDR_W, 13, character RAM address width
DATA_W, 7, character code width
CHAR_COUNT, 4800, on-screen cells (80x60); valid addresses 0..CHAR_COUNT-1
BLANK_CHAR, 7'h20, code written by the clear sweep

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester write request
req_addr  in  NREQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NREQ*DATA_W  packed character codes; requester i at [i*DATA_W +: DATA_W]
req_ready  out  NREQ  one-hot grant; a transfer happens when valid&ready are both high
clear_start  in  1  one-cycle pulse that starts a clear sweep
clear_busy  out  1  high while the sweep is running
ram_wr_en  out  1  to characterRAM wrEnA
ram_addr  out  ADDR_W  to characterRAM addrA
ram_data  out  DATA_W  to characterRAM dataWrA
grant_id  out  3  index of the requester whose write is on the RAM bus this cycle
drop_pulse  out  1  one-cycle pulse when an accepted write is discarded

Behaviour:
- Reset: state IDLE (CLEAR if CLEAR_ON_RESET_EN is defined); rr_ptr=0; ram_wr_en=0; ram_addr=0; ram_data=0; grant_id=0; drop_pulse=0; clear_busy=0 (1 if the feature is on); req_ready=0.
- Reset is asynchronous; all state registers use it. A reset in the middle of a sweep abandons the sweep immediately.
- FSM has two states.
  - IDLE: arbitrates each cycle.
  - CLEAR: sweeps cells, one per cycle.
- IDLE, req_ready (combinational, Mealy):
  - Select the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready is one-hot on that i; it is all zero if no request is valid or clear_start=1.
  - req_ready never asserts unless req_valid for the same requester is high.
- Transfer: on each transfer, next cycle ram_wr_en=1, ram_addr/ram_data are the granted requester's addr/data, and grant_id=i. Latency is 1 cycle. rr_ptr becomes (i+1) mod NREQ.
- Out-of-range address: if the granted req_addr >= CHAR_COUNT, the transfer is still accepted (ready=1). Next cycle ram_wr_en=0 and drop_pulse=1. rr_ptr advances normally.
- No transfer: ram_wr_en=0 in the following cycle; ram_addr/ram_data hold their last values.
- Throughput: 1 write per cycle sustained. A single requester with valid held high is granted every cycle.
- clear_start in IDLE:
  - Next state is CLEAR and the cell counter loads 0.
  - No grant in that cycle, even if requests are pending.
- CLEAR:
  - req_ready=0 and clear_busy=1.
  - Each cycle: ram_wr_en=1, ram_addr=counter, ram_data=BLANK_CHAR, then counter increments.
  - After the write to CHAR_COUNT-1, go to IDLE. clear_busy falls in the cycle after the last write.
  - Total: exactly CHAR_COUNT write cycles.
- clear_start during CLEAR restarts the counter at 0 (sweep restarts); no intermediate idle cycle.
- rr_ptr is unchanged by a sweep.
- Requester obligations: hold valid/addr/data stable until ready. The arbiter does not check this.

Optional Feature:
CLEAR_ON_RESET_EN
- Defined: reset exits into CLEAR with counter=0, so the screen is blanked automatically after power-up (first write at addr 0 in the first clock after rst_n rises).
- Undefined: reset exits into IDLE; the RAM contents are left untouched until clear_start.

Decomposition:
- Shared package char_ram_pkg holds:
  - constants CHAR_ADDR_W=13, CHAR_DATA_W=7, CHAR_COLS=80, CHAR_ROWS=60, CHAR_COUNT=4800, BLANK_CHAR=7'h20
  - typedef arb_state_t {IDLE, CLEAR}
- One sub-module is natural: rr_priority_picker, a combinational function of (valid vector, rr_ptr) that returns the one-hot grant and its index.

Test Plan:
1. Reset with the feature undefined, all req_valid=0 -> ram_wr_en=0, req_ready=0, clear_busy=0 for 20 cycles.
2. All 3 requesters valid continuously, with addrs 10/20/30 -> grants rotate 0,1,2,0,1,2; ram_addr sequence 10,20,30,... one cycle after each ready; no idle cycles.
3. clear_start pulse with req 1 valid the same cycle -> req_ready=0 for 4801 cycles; writes 0..4799 with data 0x20 on consecutive cycles; clear_busy high for 4800 cycles; then req 1 is granted.
4. Mid-sweep (counter=100) clear_start again -> next ram_addr=0; total of 4800 further writes.
5. Requester 2 writes addr 5000 -> ready=1, next cycle ram_wr_en=0 and drop_pulse=1; rr_ptr advances to 0.
6. With CLEAR_ON_RESET_EN, deassert rst_n mid-sweep -> outputs go to reset values immediately; after release, the sweep restarts at addr 0.
